// File: rtl/obi_mem_responder.sv
// OBI memory responder: word-addressed SRAM behind a configurable grant delay and a fixed-depth
// response pipeline. Writes commit on the grant edge; reads sample the array on the grant edge.
package obi_mem_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned GNT_DELAY  = 0,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] OOR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  req_i,
  output obi_resp_t resp_o,
  input  logic      stall_i,
  output logic      busy_o
);

  localparam int unsigned IdxW      = $clog2(NUM_WORDS);
  localparam int unsigned CntW      = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;
  localparam logic [31:0] SpanBytes = 32'(NUM_WORDS * 4);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            gnt;

  // Grant FSM; no grant is issued while reset is asserted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i.req && !stall_i && !rst_i) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(GNT_DELAY - 1);
          end
        end
      end
      StWait: begin
        if (!req_i.req) begin
          state_d = StIdle;
        end else if (!stall_i) begin
          if (cnt_q == '0) begin
            gnt     = !rst_i;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address decode; addresses below BASE_ADDR wrap to a large offset and decode out of range.
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;

  assign offset   = req_i.addr - BASE_ADDR;
  assign in_range = offset < SpanBytes;
  assign idx      = offset[IdxW+1:2];

  logic [31:0] mem [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (gnt && req_i.we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (req_i.be[i]) begin
          mem[idx][8*i +: 8] <= req_i.wdata[8*i +: 8];
        end
      end
    end
  end

  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (!req_i.we) begin
      rd_data = in_range ? mem[idx] : OOR_RDATA;
    end
  end

  logic [RD_LATENCY-1:0] vld_q;
  logic [31:0]           data_q [RD_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= gnt;
      data_q[0] <= gnt ? rd_data : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  always_comb begin
    resp_o        = '0;
    resp_o.gnt    = gnt;
    resp_o.rvalid = vld_q[RD_LATENCY-1];
    resp_o.rdata  = vld_q[RD_LATENCY-1] ? data_q[RD_LATENCY-1] : '0;
  end

  assign busy_o = |vld_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances with different timing parameters, a cycle-level
// behavioural model checking every output each cycle, a vector table and timing sequences.
module tb_obi_mem_responder;
  import obi_mem_pkg::*;

  logic      clk = 1'b0;
  obi_req_t  req_s   [3];
  obi_resp_t resp_s  [3];
  logic      stall_s [3];
  logic      rst_s   [3];
  logic      busy_s  [3];

  always #5 clk = ~clk;

  // 0: defaults, 1: back-to-back with deep pipeline, 2: grant delay with offset base
  obi_mem_responder u_fast (
    .clk_i(clk), .rst_i(rst_s[0]), .req_i(req_s[0]), .resp_o(resp_s[0]),
    .stall_i(stall_s[0]), .busy_o(busy_s[0])
  );
  obi_mem_responder #(
    .NUM_WORDS(64), .BASE_ADDR(32'h8000_0000), .GNT_DELAY(0), .RD_LATENCY(4),
    .OOR_RDATA(32'h0BAD_0BAD)
  ) u_pipe (
    .clk_i(clk), .rst_i(rst_s[1]), .req_i(req_s[1]), .resp_o(resp_s[1]),
    .stall_i(stall_s[1]), .busy_o(busy_s[1])
  );
  obi_mem_responder #(
    .NUM_WORDS(16), .BASE_ADDR(32'h0001_0000), .GNT_DELAY(2), .RD_LATENCY(3)
  ) u_slow (
    .clk_i(clk), .rst_i(rst_s[2]), .req_i(req_s[2]), .resp_o(resp_s[2]),
    .stall_i(stall_s[2]), .busy_o(busy_s[2])
  );

  int unsigned gd [3]  = '{0, 0, 2};
  int unsigned lat [3] = '{1, 4, 3};
  int unsigned nw [3]  = '{1024, 64, 16};
  logic [31:0] base [3] = '{32'h0, 32'h8000_0000, 32'h0001_0000};
  logic [31:0] oor [3]  = '{32'hDEAD_BEEF, 32'h0BAD_0BAD, 32'hDEAD_BEEF};

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endfunction

  // Behavioural model: served-cycle counter for grants, sparse memory, responses keyed by due cycle.
  logic [31:0] mm [3][1024];
  int          wcnt [3];
  bit          pv [3][16];
  logic [31:0] pd [3][16];

  function automatic void model_step(int d);
    obi_req_t    r = req_s[d];
    int          slot = cyc % 16;
    bit          eg, eb;
    longint      off;
    bit          inr;
    int          idx;
    logic [31:0] rdv;
    eg = !rst_s[d] && r.req && !stall_s[d] && (wcnt[d] == int'(gd[d]));
    eb = 1'b0;
    for (int k = 0; k < int'(lat[d]); k++) eb |= pv[d][(cyc + k) % 16];
    chk("gnt", d, 32'(resp_s[d].gnt), 32'(eg));
    chk("rvalid", d, 32'(resp_s[d].rvalid), 32'(pv[d][slot]));
    chk("rdata", d, resp_s[d].rdata, pv[d][slot] ? pd[d][slot] : 32'h0);
    chk("busy", d, 32'(busy_s[d]), 32'(eb));
    pv[d][slot] = 1'b0;
    if (rst_s[d]) begin
      for (int k = 0; k < 16; k++) pv[d][k] = 1'b0;
      wcnt[d] = 0;
    end else begin
      if (eg) begin
        off = longint'(r.addr) - longint'(base[d]);
        inr = (off >= 0) && (off < longint'(nw[d]) * 4);
        idx = inr ? int'(off / 4) : 0;
        rdv = 32'h0;
        if (r.we && inr) begin
          for (int i = 0; i < 4; i++) if (r.be[i]) mm[d][idx][8*i +: 8] = r.wdata[8*i +: 8];
        end else if (!r.we) begin
          rdv = inr ? mm[d][idx] : oor[d];
        end
        pv[d][(cyc + int'(lat[d])) % 16] = 1'b1;
        pd[d][(cyc + int'(lat[d])) % 16] = rdv;
      end
      if (!r.req || eg) wcnt[d] = 0;
      else if (!stall_s[d]) wcnt[d]++;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) model_step(d);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(int d, bit we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
    bit ok = 1'b0;
    req_s[d] = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wd};
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = resp_s[d].gnt;
      tick();
    end
    req_s[d].req = 1'b0;
    chk("xact_gnt", d, 32'(ok), 32'h1);
  endtask

  task automatic timed_read(int d, logic [31:0] addr, int stall_at, output int g, output int r,
                            output logic [31:0] rd);
    g  = -1;
    r  = -1;
    rd = '0;
    req_s[d] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0};
    for (int k = 0; k < 16; k++) begin
      stall_s[d] = (k == stall_at);
      @(negedge clk);
      if (resp_s[d].gnt && g < 0) g = k;
      if (resp_s[d].rvalid) begin
        r  = k;
        rd = resp_s[d].rdata;
      end
      tick();
      if (g >= 0) req_s[d].req = 1'b0;
    end
    stall_s[d] = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t v(logic req, logic we, logic [3:0] be, logic [31:0] addr,
                             logic [31:0] wdata, logic stall, logic gnt, logic rv,
                             logic [31:0] rd);
    v = '{req: req, we: we, be: be, addr: addr, wdata: wdata, stall: stall, gnt: gnt, rv: rv,
          rd: rd};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", nerr);
    $fatal(1);
  end

  initial begin
    vec_t        tbl [17];
    int          g, r;
    logic [31:0] rd;
    logic [31:0] a;

    tbl[0]  = v(1, 1, 4'hF, 32'h10,   32'hCAFE_F00D, 0, 1, 0, 32'h0);
    tbl[1]  = v(1, 0, 4'hF, 32'h10,   32'h0,         0, 1, 1, 32'h0);
    tbl[2]  = v(0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 1, 32'hCAFE_F00D);
    tbl[3]  = v(1, 1, 4'hF, 32'h20,   32'h1122_3344, 0, 1, 0, 32'h0);
    tbl[4]  = v(1, 1, 4'h5, 32'h20,   32'hAABB_CCDD, 0, 1, 1, 32'h0);
    tbl[5]  = v(1, 0, 4'hF, 32'h20,   32'h0,         0, 1, 1, 32'h0);
    tbl[6]  = v(0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 1, 32'h11BB_33DD);
    tbl[7]  = v(1, 1, 4'hF, 32'h0,    32'h1234_5678, 0, 1, 0, 32'h0);
    tbl[8]  = v(1, 1, 4'hF, 32'hFFC,  32'h0BAD_C0DE, 0, 1, 1, 32'h0);
    tbl[9]  = v(1, 0, 4'hF, 32'h1000, 32'h0,         0, 1, 1, 32'h0);
    tbl[10] = v(1, 1, 4'hF, 32'h1000, 32'h5,         0, 1, 1, 32'hDEAD_BEEF);
    tbl[11] = v(1, 0, 4'hF, 32'h0,    32'h0,         0, 1, 1, 32'h0);
    tbl[12] = v(1, 0, 4'hF, 32'hFFC,  32'h0,         0, 1, 1, 32'h1234_5678);
    tbl[13] = v(1, 0, 4'hF, 32'h10,   32'h0,         1, 0, 1, 32'h0BAD_C0DE);
    tbl[14] = v(1, 0, 4'hF, 32'h10,   32'h0,         0, 1, 0, 32'h0);
    tbl[15] = v(0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 1, 32'hCAFE_F00D);
    tbl[16] = v(0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 0, 32'h0);

    for (int d = 0; d < 3; d++) begin
      req_s[d]   = '0;
      stall_s[d] = 1'b0;
      rst_s[d]   = 1'b1;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    chk_en = 1'b1;

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++) xact(d, 1'b1, 4'hF, base[d] + 32'(4 * k), 32'(k));
      xact(d, 1'b1, 4'hF, base[d] + 32'(nw[d] * 4 - 4), 32'hFACE_0000 + 32'(d));
    end
    repeat (8) tick();

    // Same-cycle grant, single-cycle latency, byte enables and range limits.
    for (int i = 0; i < 17; i++) begin
      req_s[0]   = '{req: tbl[i].req, we: tbl[i].we, be: tbl[i].be, addr: tbl[i].addr,
                     wdata: tbl[i].wdata};
      stall_s[0] = tbl[i].stall;
      @(negedge clk);
      chk("tbl_gnt", i, 32'(resp_s[0].gnt), 32'(tbl[i].gnt));
      chk("tbl_rvalid", i, 32'(resp_s[0].rvalid), 32'(tbl[i].rv));
      chk("tbl_rdata", i, resp_s[0].rdata, tbl[i].rd);
      chk("tbl_busy", i, 32'(busy_s[0]), 32'(tbl[i].rv));
      tick();
    end
    req_s[0]   = '0;
    stall_s[0] = 1'b0;
    repeat (4) tick();

    // Grant delay 2, latency 3, without and with a stall in the first waiting cycle.
    timed_read(2, 32'h0001_0008, -1, g, r, rd);
    chk("slow_gnt_cycle", 2, 32'(g), 32'd2);
    chk("slow_rvalid_cycle", 2, 32'(r), 32'd5);
    chk("slow_rdata", 2, rd, 32'd2);
    timed_read(2, 32'h0001_0008, 1, g, r, rd);
    chk("stall_gnt_cycle", 2, 32'(g), 32'd3);
    chk("stall_rvalid_cycle", 2, 32'(r), 32'd6);
    chk("stall_rdata", 2, rd, 32'd2);
    repeat (4) tick();

    // Back-to-back reads of words 0..3 through a 4-deep pipeline.
    for (int k = 0; k < 12; k++) begin
      a = 32'h8000_0000 + 32'(4 * k);
      if (k < 4) req_s[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
      else req_s[1] = '0;
      @(negedge clk);
      chk("b2b_gnt", k, 32'(resp_s[1].gnt), 32'(k < 4));
      chk("b2b_rvalid", k, 32'(resp_s[1].rvalid), 32'(k >= 4 && k < 8));
      if (k >= 4 && k < 8) chk("b2b_rdata", k, resp_s[1].rdata, 32'(k - 4));
      chk("b2b_busy", k, 32'(busy_s[1]), 32'(k >= 1 && k < 8));
      tick();
    end

    // Reset with a write and a read in flight: responses vanish, the write persists.
    for (int k = 0; k < 10; k++) begin
      rst_s[1] = (k == 2);
      if (k == 0) req_s[1] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h8000_0014,
                               wdata: 32'h5A5A_5A5A};
      else if (k == 1) req_s[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h8000_0004,
                                    wdata: 32'h0};
      else req_s[1] = '0;
      @(negedge clk);
      if (k < 3) chk("rst_gnt", k, 32'(resp_s[1].gnt), 32'(k < 2));
      chk("rst_rvalid", k, 32'(resp_s[1].rvalid), 32'h0);
      chk("rst_busy", k, 32'(busy_s[1]), 32'(k == 1 || k == 2));
      tick();
    end
    timed_read(1, 32'h8000_0014, -1, g, r, rd);
    chk("post_rst_gnt_cycle", 1, 32'(g), 32'd0);
    chk("post_rst_rvalid_cycle", 1, 32'(r), 32'd4);
    chk("post_rst_rdata", 1, rd, 32'h5A5A_5A5A);

    // Random traffic including protocol violations, stalls and occasional resets.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 300; n++) begin
        int sel = int'($urandom_range(0, 10));
        if (sel < 8) a = base[d] + 32'(4 * sel);
        else if (sel == 8) a = base[d] + 32'(nw[d] * 4 - 4);
        else if (sel == 9) a = base[d] + 32'(nw[d] * 4);
        else a = base[d] - 32'd4;
        req_s[d] = '{req: ($urandom_range(0, 9) < 7), we: 1'($urandom_range(0, 1)),
                     be: 4'($urandom_range(0, 15)), addr: a, wdata: $urandom};
        stall_s[d] = ($urandom_range(0, 4) == 0);
        rst_s[d]   = ($urandom_range(0, 63) == 0);
        tick();
      end
      req_s[d]   = '0;
      stall_s[d] = 1'b0;
      rst_s[d]   = 1'b0;
      repeat (10) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
